// File: rtl/display_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : display_pkg
//  Purpose  : Shared types and constants for the multiplexed 4-digit
//             seven-segment display path (scan controller, decoder, timebase).
//  Contents : NUM_DIGITS, LZ_DIGIT, digit_idx_t, bcd_t, nibble_sel()
//  Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int NUM_DIGITS = 4;
  // Hours-tens position, the only digit eligible for leading-zero blanking.
  localparam int LZ_DIGIT   = 3;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  // Pick nibble 'idx' out of a packed {d3,d2,d1,d0} word.
  function automatic bcd_t nibble_sel(input logic [NUM_DIGITS*4-1:0] word,
                                      input digit_idx_t              idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_scan_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : display_scan_controller_if
//  Purpose  : Bundle between the timekeeping/alarm-set logic and the display
//             scan controller.
//  Ports    : master - drives digits_in, blink_mask, blink_en, lz_suppress;
//                      observes en, num, blank, frame_start, blink_phase
//             slave  - the scan controller (opposite directions)
//  Revision : 1.0 - initial release
// ============================================================================
interface display_scan_controller_if;
  import display_pkg::*;

  logic [NUM_DIGITS*4-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blink_en;
  logic                    lz_suppress;
  digit_idx_t              en;
  bcd_t                    num;
  logic                    blank;
  logic                    frame_start;
  logic                    blink_phase;

  modport master (
    output digits_in, blink_mask, blink_en, lz_suppress,
    input  en, num, blank, frame_start, blink_phase
  );

  modport slave (
    input  digits_in, blink_mask, blink_en, lz_suppress,
    output en, num, blank, frame_start, blink_phase
  );

endinterface
`default_nettype wire

// File: rtl/tick_divider.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tick_divider
//  Purpose  : Free-running 0..DIV-1 prescaler producing a registered
//             one-cycle tick in the cycle where the count equals DIV-1.
//  Ports    : clk, rst_n (async active-low)
//             tick     - registered, high while count == DIV-1
//             pre_tick - combinational, high one cycle before tick, lets
//                        callers register companion pulses aligned to tick
//  Params   : DIV (>= 2)
//  Revision : 1.0 - initial release
// ============================================================================
module tick_divider #(
  parameter int DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic pre_tick
);

  localparam int             CW     = $clog2(DIV);
  localparam logic [CW-1:0]  C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0]  C_PRE  = CW'(DIV - 2);

  logic [CW-1:0] r_count;
  logic          r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= (r_count == C_LAST) ? '0 : r_count + CW'(1);
      r_tick  <= (r_count == C_PRE);
    end
  end

  assign tick     = r_tick;
  assign pre_tick = (r_count == C_PRE);

endmodule
`default_nettype wire

// File: rtl/display_scan_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : display_scan_controller
//  Purpose  : Time-multiplexes four BCD digits onto the shared seven-segment
//             decoder. Digits are snapshotted once per frame so a frame never
//             mixes old and new values; supports per-digit blinking and
//             hours-tens leading-zero suppression.
//  Ports    : clk, rst_n (async active-low)
//             bus (slave): digits_in, blink_mask, blink_en, lz_suppress in;
//                          en, num, blank, frame_start, blink_phase out
//  Params   : SCAN_DIV (>= 2) clocks per digit slot,
//             BLINK_FRAMES (>= 1) frames per blink half-period
//  Revision : 1.0 - initial release
// ============================================================================
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                        clk,
  input  logic                        rst_n,
  display_scan_controller_if.slave    bus
);

  localparam digit_idx_t    C_LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);
  localparam digit_idx_t    C_LZ_IDX   = digit_idx_t'(LZ_DIGIT);
  localparam int            FCW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FCW-1:0] C_FR_LAST = FCW'(BLINK_FRAMES - 1);

  // --------------------------------------------------------------------------
  // Prescaler
  // --------------------------------------------------------------------------
  logic w_tick;
  logic w_pre_tick;

  tick_divider #(
    .DIV (SCAN_DIV)
  ) u_tick_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  digit_idx_t              r_idx;
  logic [NUM_DIGITS*4-1:0] r_digits_snap;
  logic [NUM_DIGITS-1:0]   r_mask_snap;
  logic                    r_lz_snap;
  logic [FCW-1:0]          r_frame_cnt;
  digit_idx_t              r_en;
  bcd_t                    r_num;
  logic                    r_blank;
  logic                    r_frame_start;
  logic                    r_blink_phase;

  // --------------------------------------------------------------------------
  // Next-slot computation
  // --------------------------------------------------------------------------
  digit_idx_t              w_idx_next;
  logic                    w_wrap;
  logic [NUM_DIGITS*4-1:0] w_digits_view;
  logic [NUM_DIGITS-1:0]   w_mask_view;
  logic                    w_lz_view;
  logic [FCW-1:0]          w_cnt_next;
  logic                    w_phase_next;
  bcd_t                    w_num_next;
  logic                    w_blank_next;

  assign w_idx_next = r_idx + digit_idx_t'(1);
  assign w_wrap     = w_tick && (r_idx == C_LAST_IDX);

  // The wrap slot must already use the values being latched on this edge,
  // so bypass the snapshot registers on a wrap.
  assign w_digits_view = w_wrap ? bus.digits_in   : r_digits_snap;
  assign w_mask_view   = w_wrap ? bus.blink_mask  : r_mask_snap;
  assign w_lz_view     = w_wrap ? bus.lz_suppress : r_lz_snap;

  // frame_start is high exactly in the wrap tick cycle, so the blink counter
  // advances on the same edge that loads the new slot. The slot's blank is
  // computed from the updated phase so phase and blanking stay coherent.
  always_comb begin
    w_cnt_next   = r_frame_cnt;
    w_phase_next = r_blink_phase;
    if (!bus.blink_en) begin
      w_cnt_next   = '0;
      w_phase_next = 1'b0;
    end else if (r_frame_start) begin
      if (r_frame_cnt == C_FR_LAST) begin
        w_cnt_next   = '0;
        w_phase_next = ~r_blink_phase;
      end else begin
        w_cnt_next   = r_frame_cnt + FCW'(1);
      end
    end
  end

  assign w_num_next   = nibble_sel(w_digits_view, w_idx_next);
  assign w_blank_next = (bus.blink_en & w_phase_next & w_mask_view[w_idx_next])
                      | ((w_idx_next == C_LZ_IDX) & w_lz_view
                         & (nibble_sel(w_digits_view, C_LZ_IDX) == 4'd0));

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx         <= C_LAST_IDX;   // first tick after reset is a wrap
      r_digits_snap <= '0;
      r_mask_snap   <= '0;
      r_lz_snap     <= 1'b0;
      r_frame_cnt   <= '0;
      r_en          <= '0;
      r_num         <= '0;
      r_blank       <= 1'b1;
      r_frame_start <= 1'b0;
      r_blink_phase <= 1'b0;
    end else begin
      r_frame_cnt   <= w_cnt_next;
      r_blink_phase <= w_phase_next;
      // Registered one cycle early so the pulse coincides with the wrap tick.
      r_frame_start <= w_pre_tick && (r_idx == C_LAST_IDX);
      if (w_tick) begin
        r_idx   <= w_idx_next;
        r_en    <= w_idx_next;
        r_num   <= w_num_next;
        r_blank <= w_blank_next;
      end
      if (w_wrap) begin
        r_digits_snap <= bus.digits_in;
        r_mask_snap   <= bus.blink_mask;
        r_lz_snap     <= bus.lz_suppress;
      end
    end
  end

  assign bus.en          = r_en;
  assign bus.num         = r_num;
  assign bus.blank       = r_blank;
  assign bus.frame_start = r_frame_start;
  assign bus.blink_phase = r_blink_phase;

endmodule
`default_nettype wire
